biquad_coeff_wb_regs: RTL and testbench

Wishbone slave register bank that receives notch-biquad coefficient writes from the host (PS or simulation master) and presents them as stable, per-biquad coefficient buses to the trigger chain's biquad stages. Coefficients are loaded sequentially into shadow FIFOs-by-offset and only become active on an explicit update write, so the datapath never sees a half-loaded filter. Sits between the Wishbone interconnect and the biquad instances inside the trigger chain, in the Wishbone clock domain.

---
 rtl/biquad_coeff_wb_regs_if.sv | 31 +++
 rtl/biquad_coeff_wb_regs.sv | 150 +++++++++++++++
 tb/tb_biquad_coeff_wb_regs.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/biquad_coeff_wb_regs_if.sv
// Wishbone classic bus bundle for the biquad coefficient register bank.
// Signals keep their slave-side names: *_i driven by the master, *_o by the slave.
//   wb_cyc_i/wb_stb_i/wb_we_i : cycle, strobe, write enable
//   wb_adr_i [7:0]            : byte address, [7] biquad index, [6:0] offset
//   wb_dat_i [31:0]           : write data
//   wb_sel_i [3:0]            : byte selects (full-word writes assumed)
//   wb_ack_o                  : acknowledge
//   wb_dat_o [31:0]           : read data
//   wb_err_o/wb_rty_o         : error / retry (never asserted)
interface biquad_coeff_wb_regs_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [7:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_ack_o;
  logic [31:0] wb_dat_o;
  logic        wb_err_o;
  logic        wb_rty_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    input  wb_ack_o, wb_dat_o, wb_err_o, wb_rty_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    output wb_ack_o, wb_dat_o, wb_err_o, wb_rty_o
  );
endinterface

// File: rtl/biquad_coeff_wb_regs.sv
// Wishbone register bank holding notch-biquad coefficients. Host writes fill
// per-group shadow slots through auto-incrementing pointers; a control write
// copies a biquad's whole shadow set to its active set in one edge so the
// datapath never sees a partially loaded filter.
//   wb_clk_i, wb_rst_n_i : clock, asynchronous active-low reset
//   wb                   : Wishbone classic slave port
//   coeff_o              : active coefficients, biquad b slot s at
//                          [(b*25+s)*COEFF_BITS +: COEFF_BITS]
//   update_o             : one-cycle pulse per biquad when its active set changes
module biquad_coeff_wb_regs #(
  parameter int NBQ        = 2,
  parameter int COEFF_BITS = 18
) (
  input  logic                            wb_clk_i,
  input  logic                            wb_rst_n_i,
  biquad_coeff_wb_regs_if.slave           wb,
  output logic [NBQ*25*COEFF_BITS-1:0]    coeff_o,
  output logic [NBQ-1:0]                  update_o
);
  localparam int NSLOT = 25;
  localparam int NGRP  = 7;

  // Group g (offset g*4, g=1..7): first slot of the group.
  function automatic logic [4:0] grp_base(input logic [2:0] g);
    case (g)
      3'd1:    grp_base = 5'd0;
      3'd2:    grp_base = 5'd2;
      3'd3:    grp_base = 5'd6;
      3'd4:    grp_base = 5'd8;
      3'd5:    grp_base = 5'd15;
      3'd6:    grp_base = 5'd23;
      default: grp_base = 5'd24;
    endcase
  endfunction

  // Group g: last pointer value before wrapping (depth-1).
  function automatic logic [2:0] grp_last(input logic [2:0] g);
    case (g)
      3'd1:    grp_last = 3'd1;
      3'd2:    grp_last = 3'd3;
      3'd3:    grp_last = 3'd1;
      3'd4:    grp_last = 3'd6;
      3'd5:    grp_last = 3'd7;
      default: grp_last = 3'd0;
    endcase
  endfunction

  logic signed [COEFF_BITS-1:0] shadow_q [NBQ][NSLOT];
  logic signed [COEFF_BITS-1:0] active_q [NBQ][NSLOT];
  logic [2:0]                   ptr_q    [NBQ][NGRP];

  logic            ack_q, ack_d;
  logic [31:0]     dat_q, dat_d;
  logic [NBQ-1:0]  upd_q, upd_d;

  logic            accept;
  logic            bq;
  logic            bq_ok;
  logic [6:0]      off;
  logic [2:0]      grp;
  logic [2:0]      gi;
  logic            ctrl_hit;
  logic            grp_hit;
  logic [2:0]      cur_ptr;
  logic [4:0]      slot;
  logic            any_nz;
  logic [31:0]     rd_val;
  logic signed [COEFF_BITS-1:0] rd_coef;
  logic            unused;

  assign unused = ^{wb.wb_sel_i, wb.wb_dat_i[31:COEFF_BITS]};

  // A new transfer is taken only when ack is low, so ack never holds two cycles.
  assign accept   = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
  assign bq       = wb.wb_adr_i[7];
  assign bq_ok    = (NBQ > 1) || (bq == 1'b0);
  assign off      = wb.wb_adr_i[6:0];
  assign grp      = off[4:2];
  assign gi       = grp - 3'd1;
  assign ctrl_hit = (off == 7'h00);
  assign grp_hit  = (off[1:0] == 2'b00) && (off[6:5] == 2'b00) && (grp != 3'd0);

  always_comb begin
    cur_ptr = 3'd0;
    slot    = 5'd0;
    any_nz  = 1'b0;
    rd_val  = 32'h0;
    rd_coef = '0;
    upd_d   = '0;
    if (bq_ok) begin
      if (grp_hit) begin
        cur_ptr = ptr_q[bq][gi];
        slot    = grp_base(grp) + {2'b00, cur_ptr};
        rd_coef = active_q[bq][slot];
        rd_val  = {{(32-COEFF_BITS){rd_coef[COEFF_BITS-1]}}, rd_coef};
      end else if (ctrl_hit) begin
        for (int g = 0; g < NGRP; g++) any_nz = any_nz | (|ptr_q[bq][g]);
        rd_val = {23'h0, any_nz, 1'b0, ptr_q[bq][4], 1'b0, ptr_q[bq][3]};
      end
      if (accept && wb.wb_we_i && ctrl_hit && wb.wb_dat_i[0]) upd_d[bq] = 1'b1;
    end
    ack_d = accept;
    dat_d = (accept && !wb.wb_we_i) ? rd_val : 32'h0;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      ack_q <= 1'b0;
      dat_q <= 32'h0;
      upd_q <= '0;
      for (int b = 0; b < NBQ; b++) begin
        for (int s = 0; s < NSLOT; s++) begin
          shadow_q[b][s] <= '0;
          active_q[b][s] <= '0;
        end
        for (int g = 0; g < NGRP; g++) ptr_q[b][g] <= 3'd0;
      end
    end else begin
      ack_q <= ack_d;
      dat_q <= dat_d;
      upd_q <= upd_d;
      if (accept && wb.wb_we_i && bq_ok) begin
        if (ctrl_hit) begin
          // Bit 0 (commit) dominates bit 1 (pointer clear); both clear pointers.
          if (wb.wb_dat_i[0]) begin
            for (int s = 0; s < NSLOT; s++) active_q[bq][s] <= shadow_q[bq][s];
          end
          if (wb.wb_dat_i[0] || wb.wb_dat_i[1]) begin
            for (int g = 0; g < NGRP; g++) ptr_q[bq][g] <= 3'd0;
          end
        end else if (grp_hit) begin
          shadow_q[bq][slot] <= wb.wb_dat_i[COEFF_BITS-1:0];
          ptr_q[bq][gi]      <= (cur_ptr == grp_last(grp)) ? 3'd0 : cur_ptr + 3'd1;
        end
      end
    end
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign wb.wb_err_o = 1'b0;
  assign wb.wb_rty_o = 1'b0;
  assign update_o    = upd_q;

  for (genvar b = 0; b < NBQ; b++) begin : g_bq
    for (genvar s = 0; s < NSLOT; s++) begin : g_slot
      assign coeff_o[(b*NSLOT+s)*COEFF_BITS +: COEFF_BITS] = active_q[b][s];
    end
  end
endmodule

// File: tb/tb_biquad_coeff_wb_regs.sv
module tb_biquad_coeff_wb_regs;
  localparam int NBQ = 2;
  localparam int CB  = 18;

  logic                    clk;
  logic                    rst_n;
  logic [NBQ*25*CB-1:0]    coeff;
  logic [NBQ-1:0]          upd;
  int                      n_vec;
  int                      n_err;
  logic [1:0]              last_upd;
  logic [31:0]             rdata;

  biquad_coeff_wb_regs_if bus();

  biquad_coeff_wb_regs #(.NBQ(NBQ), .COEFF_BITS(CB)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .wb         (bus),
    .coeff_o    (coeff),
    .update_o   (upd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [CB-1:0] slot(input int b, input int s);
    return coeff[(b*25+s)*CB +: CB];
  endfunction

  // One Wishbone transfer, started and finished #1 after a rising edge.
  task automatic bus_xfer(input logic we, input logic [7:0] a, input logic [31:0] d,
                          output logic [31:0] rd);
    int n;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = we;
    bus.wb_adr_i = a;
    bus.wb_dat_i = d;
    bus.wb_sel_i = 4'hF;
    n = 0;
    while (bus.wb_ack_o !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    n_vec++;
    if (n >= 20) begin
      n_err++;
      $display("FAIL ack_timeout adr=%h: no ack within 20 cycles", a);
    end
    rd       = bus.wb_dat_o;
    last_upd = upd;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    bus_xfer(1'b1, a, d, dummy);
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] v);
    bus_xfer(1'b0, a, 32'h0, v);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    bus.wb_adr_i = 8'h0; bus.wb_dat_i = 32'h0; bus.wb_sel_i = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (bus.wb_ack_o !== 1'b0) begin n_err++; $display("FAIL reset_ack got=%b want=0", bus.wb_ack_o); end
    n_vec++;
    if (coeff !== '0) begin n_err++; $display("FAIL reset_coeff got nonzero want=0"); end
    n_vec++;
    if (upd !== 2'b00) begin n_err++; $display("FAIL reset_update got=%b want=00", upd); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    rd(8'h00, rdata);
    n_vec++;
    if (rdata !== 32'h0) begin n_err++; $display("FAIL reset_status got=%h want=0", rdata); end
  endtask

  task automatic test_load_bq0;
    int dep[7] = '{2, 4, 2, 7, 8, 1, 1};
    int v = 1;
    for (int g = 0; g < 7; g++)
      for (int k = 0; k < dep[g]; k++) begin
        wr(8'((g + 1) * 4), 32'(v));
        v++;
      end
    n_vec++;
    if (coeff !== '0) begin n_err++; $display("FAIL bq0_pre_update coeff got nonzero want=0"); end
    wr(8'h00, 32'h1);
    n_vec++;
    if (last_upd !== 2'b01) begin n_err++; $display("FAIL bq0_update_pulse got=%b want=01", last_upd); end
    n_vec++;
    if (upd !== 2'b00) begin n_err++; $display("FAIL bq0_update_one_cycle got=%b want=00", upd); end
    n_vec++;
    if (slot(0, 0) !== 18'd1) begin n_err++; $display("FAIL bq0_slot0 got=%0d want=1", slot(0, 0)); end
    n_vec++;
    if (slot(0, 24) !== 18'd25) begin n_err++; $display("FAIL bq0_slot24 got=%0d want=25", slot(0, 24)); end
    n_vec++;
    if (slot(0, 8) !== 18'd9) begin n_err++; $display("FAIL bq0_slot8 got=%0d want=9", slot(0, 8)); end
  endtask

  task automatic test_load_bq1;
    int dep[7] = '{2, 4, 2, 7, 8, 1, 1};
    int v = 101;
    for (int g = 0; g < 7; g++)
      for (int k = 0; k < dep[g]; k++) begin
        wr(8'(8'h80 + (g + 1) * 4), 32'(v));
        v++;
      end
    wr(8'h80, 32'h1);
    n_vec++;
    if (last_upd !== 2'b10) begin n_err++; $display("FAIL bq1_update_pulse got=%b want=10", last_upd); end
    n_vec++;
    if (slot(1, 0) !== 18'd101) begin n_err++; $display("FAIL bq1_slot0 got=%0d want=101", slot(1, 0)); end
    n_vec++;
    if (slot(1, 24) !== 18'd125) begin n_err++; $display("FAIL bq1_slot24 got=%0d want=125", slot(1, 24)); end
    n_vec++;
    if (slot(0, 0) !== 18'd1 || slot(0, 24) !== 18'd25) begin
      n_err++; $display("FAIL bq0_untouched got=%0d,%0d want=1,25", slot(0, 0), slot(0, 24));
    end
  endtask

  task automatic test_wrap;
    for (int i = 7; i <= 11; i++) wr(8'h08, 32'(i));
    rd(8'h00, rdata);
    n_vec++;
    if (rdata !== 32'h100) begin n_err++; $display("FAIL wrap_status got=%h want=00000100", rdata); end
    wr(8'h00, 32'h1);
    n_vec++;
    if (slot(0, 2) !== 18'd11) begin n_err++; $display("FAIL wrap_slot2 got=%0d want=11", slot(0, 2)); end
    n_vec++;
    if (slot(0, 3) !== 18'd8 || slot(0, 4) !== 18'd9 || slot(0, 5) !== 18'd10) begin
      n_err++; $display("FAIL wrap_slot3_5 got=%0d,%0d,%0d want=8,9,10", slot(0, 3), slot(0, 4), slot(0, 5));
    end
    rd(8'h00, rdata);
    n_vec++;
    if (rdata !== 32'h0) begin n_err++; $display("FAIL wrap_ptr_cleared got=%h want=0", rdata); end
  endtask

  task automatic test_ptr_clear;
    wr(8'h10, 32'd77);
    wr(8'h10, 32'd78);
    rd(8'h00, rdata);
    n_vec++;
    if (rdata !== 32'h102) begin n_err++; $display("FAIL clr_status got=%h want=00000102", rdata); end
    wr(8'h00, 32'h2);
    n_vec++;
    if (last_upd !== 2'b00) begin n_err++; $display("FAIL clr_no_pulse got=%b want=00", last_upd); end
    rd(8'h00, rdata);
    n_vec++;
    if (rdata !== 32'h0) begin n_err++; $display("FAIL clr_status_after got=%h want=0", rdata); end
    wr(8'h10, 32'd55);
    n_vec++;
    if (last_upd !== 2'b00) begin n_err++; $display("FAIL clr_write_no_pulse got=%b want=00", last_upd); end
    n_vec++;
    if (slot(0, 8) !== 18'd9) begin n_err++; $display("FAIL clr_shadow_hidden got=%0d want=9", slot(0, 8)); end
    wr(8'h00, 32'h1);
    n_vec++;
    if (last_upd !== 2'b01) begin n_err++; $display("FAIL clr_update_pulse got=%b want=01", last_upd); end
    n_vec++;
    if (slot(0, 8) !== 18'd55 || slot(0, 9) !== 18'd78) begin
      n_err++; $display("FAIL clr_slots got=%0d,%0d want=55,78", slot(0, 8), slot(0, 9));
    end
  endtask

  task automatic test_readback;
    wr(8'h18, 32'h0003FFFF);
    wr(8'h00, 32'h3);
    n_vec++;
    if (last_upd !== 2'b01) begin n_err++; $display("FAIL both_bits_update got=%b want=01", last_upd); end
    rd(8'h18, rdata);
    n_vec++;
    if (rdata !== 32'hFFFFFFFF) begin n_err++; $display("FAIL rd_sign_ext got=%h want=ffffffff", rdata); end
    rd(8'h10, rdata);
    n_vec++;
    if (rdata !== 32'd55) begin n_err++; $display("FAIL rd_grp10 got=%h want=00000037", rdata); end
    rd(8'h8C, rdata);
    n_vec++;
    if (rdata !== 32'd107) begin n_err++; $display("FAIL rd_bq1_grp0c got=%h want=0000006b", rdata); end
    rd(8'h05, rdata);
    n_vec++;
    if (rdata !== 32'h0) begin n_err++; $display("FAIL rd_unaligned got=%h want=0", rdata); end
    rd(8'h40, rdata);
    n_vec++;
    if (rdata !== 32'h0) begin n_err++; $display("FAIL rd_unmapped got=%h want=0", rdata); end
    n_vec++;
    if (bus.wb_dat_o !== 32'h0) begin n_err++; $display("FAIL rd_dat_idle got=%h want=0", bus.wb_dat_o); end
  endtask

  task automatic test_handshake;
    logic exp_ack[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1;
    bus.wb_adr_i = 8'h40; bus.wb_dat_i = 32'd123; bus.wb_sel_i = 4'hF;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      n_vec++;
      if (bus.wb_ack_o !== exp_ack[i]) begin
        n_err++; $display("FAIL hs_ack[%0d] got=%b want=%b", i, bus.wb_ack_o, exp_ack[i]);
      end
    end
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (slot(0, 0) !== 18'd1 || slot(0, 8) !== 18'd55 || slot(0, 23) !== 18'h3FFFF || slot(0, 24) !== 18'd25) begin
      n_err++; $display("FAIL hs_unmapped_no_effect got=%0d,%0d,%h,%0d want=1,55,3ffff,25",
                        slot(0, 0), slot(0, 8), slot(0, 23), slot(0, 24));
    end
    rd(8'h00, rdata);
    n_vec++;
    if (rdata !== 32'h0) begin n_err++; $display("FAIL hs_status got=%h want=0", rdata); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    last_upd = 2'b00;
    test_reset;
    test_load_bq0;
    test_load_bq1;
    test_wrap;
    test_ptr_clear;
    test_readback;
    test_handshake;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
